// File: rtl/connect_box_param_if.sv
// Shared tile configuration bus: write strobe/address/data from the master,
// registered readback and reject pulse from the addressed sub-block.
interface connect_box_param_if;
  logic        config_en;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic [31:0] config_rdata;
  logic        config_err;

  modport master (
    output config_en, config_addr, config_data,
    input  config_rdata, config_err
  );

  modport slave (
    input  config_en, config_addr, config_data,
    output config_rdata, config_err
  );
endinterface

// File: rtl/connect_box_param.sv
// Connect box: picks one of NUM_TRACKS routing tracks for a CLB operand, with
// double-buffered (shadow/commit) selection and mode, optional inversion and output register.
module connect_box_param #(
  parameter int NUM_TRACKS = 8,
  parameter int WIDTH      = 1,
  parameter int CONFIG_ID  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 tile_id,
  connect_box_param_if.slave          cfg,
  input  logic [NUM_TRACKS*WIDTH-1:0] track_in,
  output logic [WIDTH-1:0]            block_out,
  output logic                        cfg_pending
);

  localparam int unsigned SEL_W = (NUM_TRACKS > 2) ? $clog2(NUM_TRACKS) : 1;
  localparam logic [7:0]  SUB_ID = 8'(CONFIG_ID);

  typedef enum logic [7:0] {
    REG_SEL    = 8'h00,
    REG_MODE   = 8'h01,
    REG_COMMIT = 8'h02,
    REG_STATUS = 8'h03
  } reg_e;

  typedef struct packed {
    logic invert;
    logic reg_out;
  } mode_t;

  logic [SEL_W-1:0] shadow_sel_q, shadow_sel_d;
  logic [SEL_W-1:0] active_sel_q, active_sel_d;
  mode_t            shadow_mode_q, shadow_mode_d;
  mode_t            active_mode_q, active_mode_d;
  logic             pending_q, pending_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] sel_raw;
  logic             addr_match;
  logic             hit;

  always_comb begin
    addr_match    = (cfg.config_addr[31:16] == tile_id) && (cfg.config_addr[15:8] == SUB_ID);
    hit           = cfg.config_en && addr_match;
    shadow_sel_d  = shadow_sel_q;
    active_sel_d  = active_sel_q;
    shadow_mode_d = shadow_mode_q;
    active_mode_d = active_mode_q;
    pending_d     = pending_q;
    err_d         = 1'b0;

    if (hit) begin
      case (cfg.config_addr[7:0])
        REG_SEL: begin
          if (cfg.config_data < 32'(NUM_TRACKS)) begin
            shadow_sel_d = cfg.config_data[SEL_W-1:0];
            pending_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        REG_MODE: begin
          shadow_mode_d = mode_t'(cfg.config_data[1:0]);
          pending_d     = 1'b1;
        end
        REG_COMMIT: begin
          active_sel_d  = shadow_sel_q;
          active_mode_d = shadow_mode_q;
          pending_d     = 1'b0;
        end
        REG_STATUS: ;
        default: err_d = 1'b1;
      endcase
    end

    // Readback tracks the address every cycle, independent of the write strobe.
    rdata_d = '0;
    if (addr_match) begin
      case (cfg.config_addr[7:0])
        REG_SEL:    rdata_d = 32'(shadow_sel_q);
        REG_MODE:   rdata_d = 32'(shadow_mode_q);
        REG_COMMIT: rdata_d = 32'(active_sel_q);
        REG_STATUS: rdata_d = {30'b0, pending_q, active_mode_q.reg_out};
        default:    rdata_d = '0;
      endcase
    end

    sel_raw = '0;
    for (int unsigned k = 0; k < NUM_TRACKS; k++) begin
      if (active_sel_q == SEL_W'(k)) sel_raw = track_in[k*WIDTH +: WIDTH];
    end
    out_d = sel_raw ^ {WIDTH{active_mode_q.invert}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_sel_q  <= '0;
      active_sel_q  <= '0;
      shadow_mode_q <= '0;
      active_mode_q <= '0;
      pending_q     <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      out_q         <= '0;
    end else begin
      shadow_sel_q  <= shadow_sel_d;
      active_sel_q  <= active_sel_d;
      shadow_mode_q <= shadow_mode_d;
      active_mode_q <= active_mode_d;
      pending_q     <= pending_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      out_q         <= out_d;
    end
  end

  // out_q runs in both modes so enabling reg_out never exposes a stale sample.
  assign block_out        = active_mode_q.reg_out ? out_q : out_d;
  assign cfg_pending      = pending_q;
  assign cfg.config_rdata = rdata_q;
  assign cfg.config_err   = err_q;

endmodule
